// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the FP arithmetic unit (multiplier, adder).
// Holds default field widths, operand class encoding, binary32 canonical
// constants, exception flag bit positions and small classification helpers.
package fp_pkg;

    // Default field widths (binary32)
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Exception flag vector layout: {invalid, overflow, underflow, inexact}
    localparam int FLAG_W         = 4;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Canonical binary32 encodings
    localparam logic [31:0] QNAN_SP = 32'h7FC0_0000;
    localparam logic [31:0] INF_SP  = 32'h7F80_0000;

    // Operand / result class
    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_class_e;

    // Classify one operand from its field summaries; subnormals count as zero
    function automatic fp_class_e fp_classify(input logic exp_zero,
                                              input logic exp_ones,
                                              input logic man_nz);
        fp_class_e cls;
        if (exp_zero) begin
            cls = CLS_ZERO;
        end else if (exp_ones) begin
            cls = man_nz ? CLS_NAN : CLS_INF;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

    // Class of a product given the classes of its two operands
    function automatic fp_class_e fp_mul_class(input fp_class_e ca,
                                               input fp_class_e cb);
        fp_class_e cls;
        if ((ca == CLS_NAN) || (cb == CLS_NAN)) begin
            cls = CLS_NAN;
        end else if (((ca == CLS_ZERO) && (cb == CLS_INF)) ||
                     ((ca == CLS_INF) && (cb == CLS_ZERO))) begin
            cls = CLS_NAN;
        end else if ((ca == CLS_INF) || (cb == CLS_INF)) begin
            cls = CLS_INF;
        end else if ((ca == CLS_ZERO) || (cb == CLS_ZERO)) begin
            cls = CLS_ZERO;
        end else begin
            cls = CLS_NORM;
        end
        return cls;
    endfunction

endpackage

// File: rtl/fp_multiplier_pipe_if.sv
// fp_multiplier_pipe_if: valid/ready operand and result channels of the
// pipelined FP multiplier. The flags signal exists only when FPMUL_FLAGS_EN
// is defined.
interface fp_multiplier_pipe_if
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
`ifdef FPMUL_FLAGS_EN
    logic [FLAG_W-1:0] flags;
`endif

    // Producer of operands / consumer of results
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result
`ifdef FPMUL_FLAGS_EN
        , input flags
`endif
    );

    // The multiplier itself
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result
`ifdef FPMUL_FLAGS_EN
        , output flags
`endif
    );

endinterface

// File: rtl/fp_round_rne.sv
// fp_round_rne: round-to-nearest-even and pack for a normalised significand.
// Takes the fraction bits, guard/round/sticky and a biased exponent carried in
// two extra two's-complement bits; produces the packed word with overflow to
// signed infinity and flush-to-zero below the minimum normal. Shared with the
// FP adder. Flag outputs exist only when FPMUL_FLAGS_EN is defined.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                   sign_i,
    input  logic [EXP_W+1:0]       exp_i,
    input  logic [MAN_W-1:0]       frac_i,
    input  logic                   guard_i,
    input  logic                   round_i,
    input  logic                   sticky_i,
    output logic [EXP_W+MAN_W:0]   value_o
`ifdef FPMUL_FLAGS_EN
    ,
    output logic                   overflow_o,
    output logic                   underflow_o,
    output logic                   inexact_o
`endif
);

    localparam logic [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EXP_W+1:0] EXP_MIN = {{(EXP_W+1){1'b0}}, 1'b1};

    logic             inc_s;
    logic [MAN_W:0]   frac_r_s;
    logic [EXP_W+1:0] exp_r_s;
    logic             ovf_s;
    logic             unf_s;

    // RNE increment; a fraction carry-out bumps the exponent, then range check
    always_comb begin
        inc_s    = guard_i & (round_i | sticky_i | frac_i[0]);
        frac_r_s = {1'b0, frac_i} + {{MAN_W{1'b0}}, inc_s};
        exp_r_s  = exp_i + {{(EXP_W+1){1'b0}}, frac_r_s[MAN_W]};
        ovf_s    = ($signed(exp_r_s) >= $signed(EXP_MAX));
        unf_s    = ($signed(exp_r_s) <  $signed(EXP_MIN));
    end

    // Pack: infinity on overflow, signed zero on flush, otherwise normal
    always_comb begin
        if (ovf_s) begin
            value_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf_s) begin
            value_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            value_o = {sign_i, exp_r_s[EXP_W-1:0], frac_r_s[MAN_W-1:0]};
        end
    end

`ifdef FPMUL_FLAGS_EN
    // Exception flags for the rounded value
    always_comb begin
        overflow_o  = ovf_s;
        underflow_o = unf_s;
        inexact_o   = guard_i | round_i | sticky_i | ovf_s | unf_s;
    end
`endif

endmodule

// File: rtl/fp_multiplier_pipe.sv
// fp_multiplier_pipe: pipelined IEEE-754 multiplier, valid/ready handshake,
// round-to-nearest-even, subnormals treated as zero and results flushed to
// zero below the minimum normal. Ranks: operand capture -> S1 unpack/classify
// -> S2 significand product -> S3 normalise/round/pack (output register),
// giving three cycles from acceptance to out_valid. One global advance enable
// stalls every rank together, so bubbles are kept and order is preserved.
// Define FPMUL_FLAGS_EN to add the {invalid,overflow,underflow,inexact} flags.
module fp_multiplier_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    fp_multiplier_pipe_if.slave bus
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int MW1 = MAN_W + 1;
    localparam int PW  = 2 * MAN_W + 2;

    localparam logic [EW2-1:0] BIAS   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic [W-1:0]   QNAN_W = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic            valid;
        logic            sign;
        fp_class_e       cls;
        logic [EW2-1:0]  exp;
        logic [MW1-1:0]  man_a;
        logic [MW1-1:0]  man_b;
    } s1_t;

    typedef struct packed {
        logic            valid;
        logic            sign;
        fp_class_e       cls;
        logic [EW2-1:0]  exp;
        logic [PW-1:0]   prod;
    } s2_t;

    logic             adv_s;

    logic             in_valid_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;

    s1_t              s1_d;
    s1_t              s1_q;
    s2_t              s2_d;
    s2_t              s2_q;

    logic             out_valid_d;
    logic             out_valid_q;
    logic [W-1:0]     result_d;
    logic [W-1:0]     result_q;

    logic             sa_s;
    logic             sb_s;
    logic [EXP_W-1:0] ea_s;
    logic [EXP_W-1:0] eb_s;
    logic [MAN_W-1:0] fa_s;
    logic [MAN_W-1:0] fb_s;
    fp_class_e        ca_s;
    fp_class_e        cb_s;

    logic             hi_s;
    logic [PW-2:0]    norm_s;
    logic [EW2-1:0]   exp_n_s;
    logic [MAN_W-1:0] frac_s;
    logic             guard_s;
    logic             round_s;
    logic             sticky_s;
    logic [W-1:0]     rnd_value_s;

`ifdef FPMUL_FLAGS_EN
    logic [FLAG_W-1:0] flags_d;
    logic [FLAG_W-1:0] flags_q;
    logic              rnd_ovf_s;
    logic              rnd_unf_s;
    logic              rnd_inx_s;
`endif

    // Whole pipe moves when the output register is empty or being drained
    assign adv_s        = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv_s;

    // S1: unpack, classify, product sign and biased exponent sum
    always_comb begin
        {sa_s, ea_s, fa_s} = a_q;
        {sb_s, eb_s, fb_s} = b_q;
        ca_s = fp_classify(ea_s == {EXP_W{1'b0}}, &ea_s, |fa_s);
        cb_s = fp_classify(eb_s == {EXP_W{1'b0}}, &eb_s, |fb_s);
        s1_d.valid = in_valid_q;
        s1_d.sign  = sa_s ^ sb_s;
        s1_d.cls   = fp_mul_class(ca_s, cb_s);
        s1_d.exp   = {2'b00, ea_s} + {2'b00, eb_s} - BIAS;
        s1_d.man_a = {1'b1, fa_s};
        s1_d.man_b = {1'b1, fb_s};
    end

    // S2: full-width unsigned significand product, class carried along
    always_comb begin
        s2_d.valid = s1_q.valid;
        s2_d.sign  = s1_q.sign;
        s2_d.cls   = s1_q.cls;
        s2_d.exp   = s1_q.exp;
        s2_d.prod  = s1_q.man_a * s1_q.man_b;
    end

    // S3 front: product lies in [1,4); shift by one and bump exponent when >= 2
    always_comb begin
        hi_s = s2_q.prod[PW-1];
        if (hi_s) begin
            norm_s  = s2_q.prod[PW-2:0];
            exp_n_s = s2_q.exp + {{(EW2-1){1'b0}}, 1'b1};
        end else begin
            norm_s  = {s2_q.prod[PW-3:0], 1'b0};
            exp_n_s = s2_q.exp;
        end
        frac_s   = norm_s[PW-2 -: MAN_W];
        guard_s  = norm_s[MAN_W];
        round_s  = norm_s[MAN_W-1];
        sticky_s = |norm_s[MAN_W-2:0];
    end

    fp_round_rne #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign_i      (s2_q.sign),
        .exp_i       (exp_n_s),
        .frac_i      (frac_s),
        .guard_i     (guard_s),
        .round_i     (round_s),
        .sticky_i    (sticky_s),
        .value_o     (rnd_value_s)
`ifdef FPMUL_FLAGS_EN
        ,
        .overflow_o  (rnd_ovf_s),
        .underflow_o (rnd_unf_s),
        .inexact_o   (rnd_inx_s)
`endif
    );

    // S3 back: special classes override the rounded value
    always_comb begin
        out_valid_d = s2_q.valid;
        result_d    = {W{1'b0}};
`ifdef FPMUL_FLAGS_EN
        flags_d     = {FLAG_W{1'b0}};
`endif
        case (s2_q.cls)
            CLS_NAN: begin
                result_d = QNAN_W;
`ifdef FPMUL_FLAGS_EN
                flags_d[FLAG_INVALID] = 1'b1;
`endif
            end
            CLS_INF: begin
                result_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            CLS_ZERO: begin
                result_d = {s2_q.sign, {(W-1){1'b0}}};
            end
            CLS_NORM: begin
                result_d = rnd_value_s;
`ifdef FPMUL_FLAGS_EN
                flags_d[FLAG_OVERFLOW]  = rnd_ovf_s;
                flags_d[FLAG_UNDERFLOW] = rnd_unf_s;
                flags_d[FLAG_INEXACT]   = rnd_inx_s;
`endif
            end
            default: begin
                result_d = QNAN_W;
            end
        endcase
    end

    // Operand capture, S1 and S2 ranks: load on advance, hold on stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_valid_q <= 1'b0;
            a_q        <= {W{1'b0}};
            b_q        <= {W{1'b0}};
            s1_q       <= s1_t'({$bits(s1_t){1'b0}});
            s2_q       <= s2_t'({$bits(s2_t){1'b0}});
        end else if (adv_s) begin
            in_valid_q <= bus.in_valid;
            a_q        <= bus.a;
            b_q        <= bus.b;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
        end else begin
            in_valid_q <= in_valid_q;
            a_q        <= a_q;
            b_q        <= b_q;
            s1_q       <= s1_q;
            s2_q       <= s2_q;
        end
    end

    // Output rank: result (and flags) stay frozen while the consumer stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= {W{1'b0}};
`ifdef FPMUL_FLAGS_EN
            flags_q     <= {FLAG_W{1'b0}};
`endif
        end else if (adv_s) begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
`ifdef FPMUL_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end else begin
            out_valid_q <= out_valid_q;
            result_q    <= result_q;
`ifdef FPMUL_FLAGS_EN
            flags_q     <= flags_q;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
`ifdef FPMUL_FLAGS_EN
    assign bus.flags     = flags_q;
`endif

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// tb_fp_multiplier_pipe: scoreboard bench for the pipelined FP multiplier.
// Expected results are queued when an operand pair is presented to a ready
// DUT and compared in order as results are handed out.
module tb_fp_multiplier_pipe;
    import fp_pkg::*;

    // Pushed on the negedge before the accepting edge, popped on the negedge
    // after out_valid rises: three clock cycles of latency span four edges.
    localparam int LAT_EDGES = 4;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        bit          lat;
        int          t;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb_q[$];

    logic [31:0] cur_res;
    logic [3:0]  cur_flg;
    bit          cur_lat;
    string       cur_tag;
    logic [31:0] held_res;

    fp_multiplier_pipe_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back('{cur_res, cur_flg, cur_lat, cyc, cur_tag});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_out", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq({e.tag, "_res"}, 64'(bus.result), 64'(e.res));
`ifdef FPMUL_FLAGS_EN
                    check_eq({e.tag, "_flags"}, 64'(bus.flags), 64'(e.flg));
`endif
                    if (e.lat) check_eq({e.tag, "_lat"}, 64'(cyc - e.t), 64'(LAT_EDGES));
                end
            end
        end
    end

    // Present one operand pair (call at posedge+1); returns posedge+1 after acceptance
    task automatic send(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] er, input logic [3:0] ef, input bit lat);
        int n = 0;
        cur_res = er; cur_flg = ef; cur_lat = lat; cur_tag = tag;
        bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq({"send_timeout_", tag}, {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) until every queued expectation has been consumed
    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({"drain_", tag}, 64'(sb_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
`ifdef FPMUL_FLAGS_EN
        check_eq("rst_flags", 64'(bus.flags), 64'd0);
`endif
        @(posedge clk); #1;

        // Single op with latency
        send("mul3x2", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 1'b1);
        wait_drain("single", 20);

        // Back-to-back stream, then the rounding/special/underflow corners
        send("neg6",   32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 4'b0000, 1'b1);
        send("sq1p5",  32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 1'b1);
        send("rne",    32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, 1'b1);
        send("ovf",    32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 4'b0101, 1'b1);
        send("zinf",   32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 1'b1);
        send("negz",   32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0000, 1'b1);
        send("ftz",    32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, 1'b1);
        send("daz",    32'h0040_0000, 32'h4000_0000, 32'h0000_0000, 4'b0000, 1'b1);
        send("infneg", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0000, 1'b1);
        send("nanin",  32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1'b1);
        wait_drain("stream", 30);

        // Backpressure: four ops issued with the consumer stalled
        bus.out_ready = 1'b0;
        send("st0", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 1'b0);
        send("st1", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 1'b0);
        send("st2", 32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 4'b0000, 1'b0);
        send("st3", 32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000, 4'b0000, 1'b0);
        @(negedge clk);
        held_res = bus.result;
        check_eq("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            check_eq("stall_hold", 64'(bus.result), 64'(held_res));
        end
        check_eq("stall_first", 64'(held_res), 64'h40C0_0000);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain("stall", 30);

        // Reset with results parked in the pipe: nothing may emerge afterwards
        bus.out_ready = 1'b0;
        send("rs0", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 1'b0);
        send("rs1", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("park_valid", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_flush_valid", {63'd0, bus.out_valid}, 64'd0);
        check_eq("rst_flush_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk); #1;

        // Recovery after reset
        send("post_rst", 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 1'b1);
        wait_drain("post_rst", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
